// File: rtl/neuron_input_arbiter.sv
// neuron_input_arbiter
//   Round-robin arbiter sharing the bundled-data input channel of one asynchronous neuron among
//   N_REQ clocked spike sources. Each source talks four-phase req/ack with the arbiter; each grant
//   runs one complete four-phase transaction toward the neuron, with nrn_data held SETUP_CYC+1
//   cycles before nrn_req rises and nrn_ack brought in through a two-flop synchronizer.
//
//   Optional macro NRN_ACK_TIMEOUT_EN: adds an ack watchdog (TIMEOUT_CYC cycles in REQ_HI/REQ_LO)
//   that aborts the neuron handshake, releases the requester and sets the sticky err flag.
//   Without it err is tied low and the neuron handshake waits indefinitely.
//
// Ports
//   clk      clock
//   rst      synchronous reset, active-low
//   req_i    per-requester four-phase request
//   data_i   per-requester data, requester k at [k*DATA_W +: DATA_W]
//   ack_o    per-requester acknowledge (at most one bit high)
//   nrn_data data toward the neuron
//   nrn_req  request toward the neuron
//   nrn_ack  acknowledge from the neuron (asynchronous)
//   gnt_idx  index of the current or last granted requester
//   busy     high whenever the FSM is not idle
//   err      sticky ack-timeout flag
module neuron_input_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 1,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_W-1:0]    data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [DATA_W-1:0]          nrn_data,
  output logic                       nrn_req,
  input  logic                       nrn_ack,
  output logic [$clog2(N_REQ)-1:0]   gnt_idx,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || DATA_W < 1 || SETUP_CYC > 255 || TIMEOUT_CYC < 1)
  begin : g_bad_params
    $error("neuron_input_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StSetup, StReqHi, StReqLo, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   ack_s1_q, ack_s_q;
  logic [7:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   nrn_req_q, nrn_req_d;
  logic                   busy_q, busy_d;

  logic [DATA_W-1:0]      data_arr [N_REQ];
  logic                   any_cand;
  logic [IdxW-1:0]        win;

  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
  end

  // Search ptr+1, ptr+2, ... wrapping at N_REQ; first pending, unacknowledged requester wins.
  always_comb begin
    logic [IdxW-1:0] k;
    any_cand = 1'b0;
    win      = '0;
    k        = ptr_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      k = (k == IdxW'(N_REQ - 1)) ? '0 : k + 1'b1;
      if (!any_cand && req_i[k] && !ack_q[k]) begin
        any_cand = 1'b1;
        win      = k;
      end
    end
  end

`ifdef NRN_ACK_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    data_d    = data_q;
    nrn_req_d = nrn_req_q;
    busy_d    = busy_q;
`ifdef NRN_ACK_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_cand) begin
          gnt_d   = win;
          data_d  = data_arr[win];
          cnt_d   = 8'(SETUP_CYC);
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == 8'd0) begin
          nrn_req_d = 1'b1;
          state_d   = StReqHi;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StReqHi: begin
        if (ack_s_q) begin
          nrn_req_d = 1'b0;
          state_d   = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_s_q) begin
          ack_d        = '0;
          ack_d[gnt_q] = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        // Committed transaction: leave as soon as the granted requester is seen low.
        if (!req_i[gnt_q]) begin
          ack_d   = '0;
          ptr_d   = gnt_q;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef NRN_ACK_TIMEOUT_EN
    // Leaving SETUP is the only way into REQ_HI, so clearing there covers entry.
    if (state_q == StSetup) begin
      wdog_d = '0;
    end else if (state_q == StReqHi || state_q == StReqLo) begin
      if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
        nrn_req_d    = 1'b0;
        err_d        = 1'b1;
        ack_d        = '0;
        ack_d[gnt_q] = 1'b1;
        state_d      = StDone;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      ack_s1_q  <= 1'b0;
      ack_s_q   <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= IdxW'(N_REQ - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      nrn_req_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef NRN_ACK_TIMEOUT_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ack_s1_q  <= nrn_ack;
      ack_s_q   <= ack_s1_q;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      nrn_req_q <= nrn_req_d;
      busy_q    <= busy_d;
`ifdef NRN_ACK_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  assign ack_o    = ack_q;
  assign nrn_data = data_q;
  assign nrn_req  = nrn_req_q;
  assign gnt_idx  = gnt_q;
  assign busy     = busy_q;
`ifdef NRN_ACK_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_input_arbiter.sv
// Self-checking bench for neuron_input_arbiter: randomized requests, random neuron ack latency,
// transaction-level round-robin reference model; with NRN_ACK_TIMEOUT_EN also the ack watchdog.
module tb_neuron_input_arbiter;

  localparam int unsigned NReq       = 4;
  localparam int unsigned DataW      = 1;
  localparam int unsigned SetupCyc   = 2;
  localparam int unsigned TimeoutCyc = 64;
  localparam int          Bound      = 300;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NReq-1:0]         req_i;
  logic [NReq*DataW-1:0]   data_i;
  logic [NReq-1:0]         ack_o;
  logic [DataW-1:0]        nrn_data;
  logic                    nrn_req;
  logic                    nrn_ack;
  logic [$clog2(NReq)-1:0] gnt_idx;
  logic                    busy;
  logic                    err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          exp_ptr;
  bit          nrn_mute = 1'b0;

  neuron_input_arbiter #(
    .N_REQ      (NReq),
    .DATA_W     (DataW),
    .SETUP_CYC  (SetupCyc),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .nrn_data(nrn_data),
    .nrn_req (nrn_req),
    .nrn_ack (nrn_ack),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round robin: first pending requester after the last granted one, cyclically.
  function automatic int rr_pick(input int ptr, input logic [NReq-1:0] pend);
    for (int i = 1; i <= int'(NReq); i++) begin
      if (pend[(ptr + i) % int'(NReq)]) return (ptr + i) % int'(NReq);
    end
    return -1;
  endfunction

  function automatic logic [DataW-1:0] data_of(input int k);
    return data_i[k*DataW +: DataW];
  endfunction

  task automatic raise_req(input int k);
    req_i[k] = 1'b1;
    data_i[k*DataW +: DataW] = DataW'($urandom);
  endtask

  // Neuron: follows nrn_req with a random 0..3 cycle latency on each edge.
  initial begin
    int dly = 0;
    nrn_ack = 1'b0;
    forever begin
      tick();
      if (nrn_mute) begin
        nrn_ack = 1'b0;
        dly     = 0;
      end else if (nrn_req != nrn_ack) begin
        if (dly == 0) begin
          nrn_ack = nrn_req;
          dly     = int'($urandom_range(0, 3));
        end else begin
          dly--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ack_o != '0) check_val("ack_onehot", $countones(ack_o), 1);
  end

  // One full transaction, starting with the DUT idle. Returns the granted index.
  task automatic run_txn(input bit withdraw, input bit late, output int k);
    int c;
    int j;
    logic [DataW-1:0] want_d;
    for (int i = 0; i < int'(NReq); i++) begin
      if (!req_i[i] && $urandom_range(0, 1) == 1) raise_req(i);
    end
    if (req_i == '0) raise_req(int'($urandom_range(0, NReq - 1)));
    k      = rr_pick(exp_ptr, req_i);
    want_d = data_of(k);
    tick();
    check_val("grant_busy", busy, 1);
    check_val("grant_idx", gnt_idx, k);
    check_val("grant_data", nrn_data, want_d);
    check_val("grant_nrn_req", nrn_req, 0);
    if (withdraw) req_i[k] = 1'b0;
    c = 0;
    while (!nrn_req && c < Bound) begin
      tick();
      c++;
    end
    check_val("setup_delay", c, SetupCyc + 1);
    check_val("req_hi_data", nrn_data, want_d);
    if (late) begin
      j = int'($urandom_range(0, NReq - 1));
      for (int i = 0; i < int'(NReq); i++) begin
        if (!req_i[(j + i) % int'(NReq)] && (j + i) % int'(NReq) != k) begin
          raise_req((j + i) % int'(NReq));
          break;
        end
      end
    end
    c = 0;
    while (ack_o == '0 && c < Bound) begin
      tick();
      c++;
    end
    check_val("ack_in_time", c < Bound, 1);
    check_val("ack_idx", ack_o, 32'(1) << k);
    check_val("ack_nrn_req", nrn_req, 0);
    check_val("ack_data", nrn_data, want_d);
    if (!withdraw) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_val("ack_hold", ack_o, 32'(1) << k);
      end
      req_i[k] = 1'b0;
    end
    tick();
    check_val("release_ack", ack_o, 0);
    check_val("release_busy", busy, 0);
    check_val("release_gnt", gnt_idx, k);
    check_val("release_err", err, 0);
    exp_ptr = k;
  endtask

  initial begin
    int k;
    int c;
    rst     = 1'b0;
    req_i   = '0;
    data_i  = '0;
    exp_ptr = NReq - 1;
    repeat (3) tick();
    check_val("rst_ack", ack_o, 0);
    check_val("rst_nrn_data", nrn_data, 0);
    check_val("rst_nrn_req", nrn_req, 0);
    check_val("rst_gnt", gnt_idx, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err, 0);
    rst = 1'b1;
    tick();

    // Single spike from requester 0 carrying a 1.
    req_i[0] = 1'b1;
    data_i[0*DataW +: DataW] = DataW'(1);
    run_txn(1'b0, 1'b0, k);
    check_val("single_gnt", k, 0);

    // All requesters kept requesting: strict rotation 1,2,3,0,1.
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < int'(NReq); i++) if (!req_i[i]) raise_req(i);
      run_txn(1'b0, 1'b0, k);
      check_val("rr_order", k, (n + 1) % int'(NReq));
    end

    // Randomized traffic with early withdrawals and late arrivals.
    for (int n = 0; n < 40; n++) begin
      run_txn($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, k);
    end

`ifdef NRN_ACK_TIMEOUT_EN
    // Neuron never answers: watchdog aborts TimeoutCyc cycles after nrn_req rises.
    nrn_mute = 1'b1;
    if (req_i == '0) raise_req(1);
    k = rr_pick(exp_ptr, req_i);
    c = 0;
    while (!nrn_req && c < Bound) begin
      tick();
      c++;
    end
    check_val("wd_nrn_req_rise", nrn_req, 1);
    repeat (TimeoutCyc - 1) tick();
    check_val("wd_before_req", nrn_req, 1);
    check_val("wd_before_err", err, 0);
    tick();
    check_val("wd_nrn_req", nrn_req, 0);
    check_val("wd_err", err, 1);
    check_val("wd_ack", ack_o, 32'(1) << k);
    req_i[k] = 1'b0;
    tick();
    check_val("wd_release", ack_o, 0);
    repeat (5) tick();
    check_val("wd_err_sticky", err, 1);
    exp_ptr  = k;
    nrn_mute = 1'b0;
    repeat (4) tick();
`endif

    // Reset while nrn_req is high abandons the transaction.
    req_i = '0;
    raise_req(2);
    c = 0;
    while (!nrn_req && c < Bound) begin
      tick();
      c++;
    end
    check_val("mid_nrn_req_hi", nrn_req, 1);
    rst      = 1'b0;
    nrn_mute = 1'b1;
    tick();
    check_val("mid_rst_nrn_req", nrn_req, 0);
    check_val("mid_rst_ack", ack_o, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_gnt", gnt_idx, 0);
    check_val("mid_rst_err", err, 0);
    req_i = '0;
    tick();
    rst      = 1'b1;
    nrn_mute = 1'b0;
    exp_ptr  = NReq - 1;
    tick();
    for (int i = 0; i < int'(NReq); i++) raise_req(i);
    run_txn(1'b0, 1'b0, k);
    check_val("post_rst_gnt", k, 0);
    run_txn(1'b0, 1'b1, k);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, want completion");
    $fatal(1);
  end

endmodule

// File: doc/neuron_input_arbiter.md
Name: neuron_input_arbiter

Overview:
- Clocked round-robin arbiter that shares the single bundled-data input channel of one asynchronous neuron among N_REQ presynaptic requesters.
- Each requester uses a four-phase req/ack handshake with the arbiter.
- The arbiter runs one complete four-phase transaction per grant toward the neuron (data_in/req_in/ack_in), with a programmable data-setup delay and a two-flop synchronizer on the neuron acknowledge.
- Sits between spike sources (clocked logic) and the neuron instance.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- DATA_W, 1: data width per requester and toward the neuron (neuron data_in is 1 bit).
- SETUP_CYC, 2: clock cycles nrn_data is held stable before nrn_req rises (bundled-data margin; 0..255).
- TIMEOUT_CYC, 64: ack watchdog limit. Used only with NRN_ACK_TIMEOUT_EN.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-low.
- req_i, in, N_REQ: per-requester four-phase request; synchronous to clk.
- data_i, in, N_REQ*DATA_W: per-requester data; requester k occupies bits [k*DATA_W +: DATA_W]; stable while req_i[k]=1.
- ack_o, out, N_REQ: per-requester acknowledge.
- nrn_data, out, DATA_W: to neuron data_in.
- nrn_req, out, 1: to neuron req_in.
- nrn_ack, in, 1: from neuron ack_in; asynchronous.
- gnt_idx, out, clog2(N_REQ): index of the current or last granted requester.
- busy, out, 1: high in any state other than IDLE.
- err, out, 1: sticky ack-timeout flag.

Behaviour:
- Reset (rst=0 at clk edge):
  - ack_o=0, nrn_data=0, nrn_req=0, gnt_idx=0, busy=0, err=0.
  - State=IDLE, rr pointer=N_REQ-1 (so requester 0 wins first), synchronizer flops=0, counters=0.
  - Reset mid-transaction abandons it: nrn_req drops at that edge. The neuron is reset by the same system reset.
- All outputs are registered. nrn_ack passes through 2 flops (ack_s) before use.
- FSM states:
  - IDLE: if any req_i[k]=1 with ack_o[k]=0, pick the first such k searching ptr+1, ptr+2, ... modulo N_REQ. At the next edge: gnt_idx=k, nrn_data=data_i[k], cnt=SETUP_CYC, busy=1, go to SETUP. Otherwise stay.
  - SETUP: if cnt=0, set nrn_req=1 and go to REQ_HI; else decrement cnt. nrn_req rises exactly SETUP_CYC+1 cycles after nrn_data is loaded.
  - REQ_HI: wait for ack_s=1, then nrn_req=0 and go to REQ_LO.
  - REQ_LO: wait for ack_s=0, then ack_o[gnt_idx]=1 and go to DONE.
  - DONE: wait for req_i[gnt_idx]=0, then ack_o[gnt_idx]=0, ptr=gnt_idx, busy=0, go to IDLE.
- Arbitration happens only in IDLE. A request arriving in any other state waits. At most one ack_o bit is high at any time.
- Once granted, a transaction is committed. If the requester drops req_i before its ack, the transaction still completes toward the neuron, and DONE exits on the first cycle req_i is seen low.
- nrn_data holds its value from IDLE exit until the next grant. It never changes while nrn_req=1 or while in REQ_LO.
- Minimum turnaround per spike with immediate acks is SETUP_CYC+1 + 2x(2 sync + 1) + DONE + IDLE cycles.
- Fairness: a requester holding req high continuously is served within N_REQ grants.
- Simultaneous events: in DONE, the release of one requester and a new request from another arbitrate on the following IDLE cycle, never in the same cycle.

Optional Feature:
- Macro: NRN_ACK_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to REQ_HI and counts every cycle in REQ_HI and REQ_LO.
  - When it reaches TIMEOUT_CYC: nrn_req=0, err=1 (sticky until reset), ack_o[gnt_idx]=1, go to DONE. The requester is released so the system cannot deadlock.
- Not defined: no watchdog logic is built; REQ_HI/REQ_LO wait indefinitely; err is tied to 0.

Test Plan:
- Reset, then single spike: SETUP_CYC=2, req_i=4'b0001, data_i[0]=1, neuron model acks 3 cycles after req and drops 3 cycles after req falls.
  -> nrn_data=1 one cycle after request; nrn_req rises 3 cycles later; ack_o[0] rises after ack_s falls; ack_o[0] clears one cycle after req_i[0]=0; gnt_idx=0.
- Round-robin: req_i=4'b1111 held, re-raised after each ack.
  -> grant order 0,1,2,3,0; nrn_data matches data_i of each granted requester; never two ack_o bits high.
- Late arrival: req_i[2] rises while requester 1 is in REQ_HI.
  -> requester 2 is granted only after requester 1 completes DONE; transaction 1 is unaffected.
- Requester withdraws early: req_i[3] is dropped in SETUP.
  -> nrn_req still pulses once; ack_o[3] pulses for one cycle; FSM returns to IDLE.
- Reset mid-transaction: rst=0 while nrn_req=1.
  -> at that edge nrn_req=0, ack_o=0, busy=0, gnt_idx=0; after release, a request from requester 0 is served first.
- With NRN_ACK_TIMEOUT_EN and TIMEOUT_CYC=64, neuron never acks.
  -> 64 cycles after nrn_req rises: nrn_req=0, err=1, ack_o[gnt] asserted; err stays 1 until reset.
